sram_stream_reader: RTL and testbench

Streaming read engine for the 8x256 64-bit SRAM bank. It accepts a (start address, length) command and issues sequential single-cycle reads on the SRAM port. It absorbs the SRAM's one-cycle read latency in a 4-entry output FIFO and presents the words as a valid/ready stream with a last flag. It sits between the bank and downstream consumers such as the systolic-array operand feeders, and is the read-side counterpart to the bank's writers.

---
 rtl/sram_stream_reader.sv | 154 +++++++++++++++
 tb/tb_sram_stream_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_reader.sv
// Streaming read engine: turns an (addr, len) command into sequential SRAM reads
// and returns the words as a valid/ready stream through a small credit-managed FIFO.
module sram_stream_reader #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W:0]   cmd_len_i,
  output logic              sram_en_o,
  output logic              sram_rw_mode_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [DATA_W-1:0] sram_rd_data_i,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_last_o,
  output logic              busy_o
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  // Wide enough for fifo count plus one in-flight plus one issuing read.
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(1 << ADDR_W);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              sram_last_q, sram_last_d;
  logic              inflight_q, inflight_last_q;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            fifo_d [FIFO_DEPTH];

  logic              sram_en_d, valid_d, busy_d, cmd_ready_d;
  logic [ADDR_W-1:0] sram_addr_d;
  logic [LEN_W-1:0]  len_sat;
  logic [CNT_W-1:0]  wr_idx;
  logic              pop, push, credit_ok;

  assign pop     = data_valid_o & data_ready_i;
  assign push    = inflight_q;
  assign len_sat = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  assign wr_idx  = count_q - CNT_W'(pop);
  // Decides the issue for the next cycle: its credit view is next-cycle count plus
  // the read issuing now (which becomes next cycle's in-flight word).
  assign credit_ok = (count_d + CNT_W'(sram_en_o)) < CNT_W'(FIFO_DEPTH);

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    sram_en_d   = 1'b0;
    sram_addr_d = sram_addr_o;
    sram_last_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o && (len_sat != '0)) begin
          sram_en_d   = 1'b1;
          sram_addr_d = cmd_addr_i;
          addr_d      = cmd_addr_i + ADDR_W'(1);
          rem_d       = len_sat - LEN_W'(1);
          sram_last_d = (len_sat == LEN_W'(1));
          state_d     = (len_sat == LEN_W'(1)) ? DRAIN : READ;
        end
      end
      READ: begin
        if (credit_ok) begin
          sram_en_d   = 1'b1;
          sram_addr_d = addr_q;
          addr_d      = addr_q + ADDR_W'(1);
          rem_d       = rem_q - LEN_W'(1);
          sram_last_d = (rem_q == LEN_W'(1));
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_q[0].last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  // Shift FIFO: entry 0 is the stream head, so the stream outputs come straight off flops
  always_comb begin
    fifo_d = fifo_q;
    if (pop) begin
      for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
      fifo_d[FIFO_DEPTH-1] = '0;
    end
    if (push) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (CNT_W'(i) == wr_idx) fifo_d[i] = '{last: inflight_last_q, data: sram_rd_data_i};
      end
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      sram_last_q     <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      count_q         <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      sram_en_o       <= 1'b0;
      sram_addr_o     <= '0;
      data_valid_o    <= 1'b0;
      busy_o          <= 1'b0;
      cmd_ready_o     <= 1'b1;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      sram_last_q     <= sram_last_d;
      inflight_q      <= sram_en_o;
      inflight_last_q <= sram_last_q;
      count_q         <= count_d;
      fifo_q          <= fifo_d;
      sram_en_o       <= sram_en_d;
      sram_addr_o     <= sram_addr_d;
      data_valid_o    <= valid_d;
      busy_o          <= busy_d;
      cmd_ready_o     <= cmd_ready_d;
    end
  end

  assign sram_rw_mode_o = 1'b0;
  assign data_o         = fifo_q[0].data;
  assign data_last_o    = fifo_q[0].last;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboard bench for sram_stream_reader: commands push expected SRAM addresses and
// stream words into queues; a negedge monitor pops and compares against the DUT.
module tb_sram_stream_reader;

  logic        clk;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [7:0]  cmd_addr_i;
  logic [8:0]  cmd_len_i;
  logic        sram_en_o;
  logic        sram_rw_mode_o;
  logic [7:0]  sram_addr_o;
  logic [63:0] sram_rd_data_i;
  logic        data_valid_o;
  logic        data_ready_i;
  logic [63:0] data_o;
  logic        data_last_o;
  logic        busy_o;

  sram_stream_reader dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_addr_i     (cmd_addr_i),
    .cmd_len_i      (cmd_len_i),
    .sram_en_o      (sram_en_o),
    .sram_rw_mode_o (sram_rw_mode_o),
    .sram_addr_o    (sram_addr_o),
    .sram_rd_data_i (sram_rd_data_i),
    .data_valid_o   (data_valid_o),
    .data_ready_i   (data_ready_i),
    .data_o         (data_o),
    .data_last_o    (data_last_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: one-cycle read latency
  logic [63:0] sram [256];
  always @(posedge clk) if (sram_en_o) sram_rd_data_i <= sram[sram_addr_o];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
  endtask

  // Scoreboard queues and monitor bookkeeping
  logic [7:0]  exp_addr_q [$];
  logic [64:0] exp_word_q [$];
  int hs_cyc, first_en_cyc = -1, first_valid_cyc = -1, done_cyc = -1;
  int issued = 0, popped = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_cmd_ready = 1'b1;
  logic [63:0] prev_data = '0;
  logic rand_ready = 1'b0;

  // Reference model: a command is the list of saturated-length sequential addresses
  task automatic model_cmd(input logic [7:0] a, input int len);
    int sat;
    logic [7:0] wa;
    sat = (len > 256) ? 256 : len;
    for (int i = 0; i < sat; i++) begin
      wa = 8'(int'(a) + i);
      exp_addr_q.push_back(wa);
      exp_word_q.push_back({(i == sat - 1), sram[wa]});
    end
  endtask

  always @(negedge clk) begin
    logic [64:0] w;
    if (!rst_ni) begin
      exp_addr_q.delete();
      exp_word_q.delete();
      issued = 0;
      popped = 0;
      prev_valid = 1'b0;
      prev_cmd_ready = 1'b1;
    end else begin
      if (cmd_valid_i && cmd_ready_o) begin
        first_en_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
      end
      if (!prev_cmd_ready && cmd_ready_o) done_cyc = cyc;
      prev_cmd_ready = cmd_ready_o;
      if (sram_en_o) begin
        if (first_en_cyc < 0) first_en_cyc = cyc;
        issued++;
        check("credit_limit", 64'(issued - popped <= 4), 64'd1);
        check("sram_rw_mode", 64'(sram_rw_mode_o), 64'd0);
        if (exp_addr_q.size() == 0) fail_now("unexpected_sram_read");
        else check("sram_addr", 64'(sram_addr_o), 64'(exp_addr_q.pop_front()));
      end
      if (prev_valid && !prev_ready) begin
        check("stall_valid", 64'(data_valid_o), 64'd1);
        check("stall_data", data_o, prev_data);
        check("stall_last", 64'(data_last_o), 64'(prev_last));
      end
      if (data_valid_o) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (data_ready_i) begin
          popped++;
          if (exp_word_q.size() == 0) fail_now("unexpected_word");
          else begin
            w = exp_word_q.pop_front();
            check("stream_data", data_o, w[63:0]);
            check("stream_last", 64'(data_last_o), 64'(w[64]));
          end
        end
      end
      prev_valid = data_valid_o;
      prev_ready = data_ready_i;
      prev_data  = data_o;
      prev_last  = data_last_o;
    end
  end

  // Consumer ready: always 1, or 50% random
  initial begin
    data_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      data_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic issue(input logic [7:0] a, input int len);
    bit ok = 0;
    cmd_addr_i  = a;
    cmd_len_i   = 9'(len);
    cmd_valid_i = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cmd_ready_o) begin ok = 1; break; end
    end
    if (!ok) fail_now("cmd_accept_timeout");
    else begin
      hs_cyc = cyc;
      model_cmd(a, len);
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_word_q.size() == 0 && exp_addr_q.size() == 0 && cmd_ready_o && !data_valid_o) begin
        ok = 1; break;
      end
    end
    if (!ok) fail_now("cmd_done_timeout");
    @(posedge clk); #1;
  endtask

  task automatic check_timing(input int sat);
    check("first_issue_cycle", 64'(first_en_cyc), 64'(hs_cyc + 1));
    check("first_word_cycle", 64'(first_valid_cyc), 64'(hs_cyc + 3));
    check("ready_return_cycle", 64'(done_cyc), 64'(hs_cyc + 3 + sat));
  endtask

  task automatic check_reset_vals();
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_sram_en", 64'(sram_en_o), 64'd0);
    check("rst_sram_addr", 64'(sram_addr_o), 64'd0);
    check("rst_valid", 64'(data_valid_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_last", 64'(data_last_o), 64'd0);
  endtask

  initial begin
    int len;
    bit ok;
    for (int i = 0; i < 256; i++) sram[i] = {$urandom, $urandom};
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1 rst_ni = 1'b1;
    @(posedge clk); #1;

    // Basic command with exact cycle timing
    issue(8'h10, 4); wait_done(); check_timing(4);
    // Address wrap FE, FF, 00, 01
    issue(8'hFE, 4); wait_done(); check_timing(4);
    // Backpressure
    rand_ready = 1'b1;
    issue(8'($urandom), 16); wait_done();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    // Full length and saturated length
    issue(8'h00, 256); wait_done(); check_timing(256);
    issue(8'h00, 300); wait_done(); check_timing(256);
    // len=0 then an immediate single-word command
    issue(8'h33, 0);
    check("len0_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("len0_busy", 64'(busy_o), 64'd0);
    issue(8'h05, 1); wait_done(); check_timing(1);
    // Random commands, random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(257, 511)) : int'($urandom_range(0, 40));
      issue(8'($urandom), len); wait_done();
    end
    rand_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    // Reset in the middle of a command
    issue(8'h80, 10);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (popped >= 3) begin ok = 1; break; end
    end
    if (!ok) fail_now("mid_cmd_progress_timeout");
    @(posedge clk); #1 rst_ni = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1 rst_ni = 1'b1;
    @(posedge clk); #1;
    issue(8'h40, 2); wait_done(); check_timing(2);
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
